// File: rtl/rv_test_sequencer_pkg.sv
// Shared definitions for the CPU test-harness sequencer.
// Also holds the tohost address used by data-memory decode and benches.
package rv_test_sequencer_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        DONE     = 2'd2
    } seq_state_e;

    localparam logic [31:0] TOHOST_PASS         = 32'd1;
    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

endpackage

// File: rtl/rv_test_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
// Clear has priority over increment.
module sat_counter
    import rv_test_sequencer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/rv_test_sequencer.sv
// Test-harness controller: CPU reset sequencing over run phases,
// tohost pass/fail detection, cycle/retire counting and timeout.
module rv_test_sequencer
    import rv_test_sequencer_pkg::*;
#(
    parameter int NUM_PHASES   = 2,
    parameter int RESET_CYCLES = 2,
    parameter int PHASE_CYCLES = 20,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(DEFAULT_TOHOST_ADDR)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        mem_write,
    input  logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_wdata,
    input  logic                        wb_valid,
    output logic                        cpu_rst,
    output logic [$clog2(NUM_PHASES):0] phase,
    output logic [CNT_W-1:0]            cycle_cnt,
    output logic [CNT_W-1:0]            retire_cnt,
    output logic                        done,
    output logic                        pass,
    output logic                        fail,
    output logic                        timeout,
    output logic [DATA_W-2:0]           fail_code
);

    localparam int PH_W  = $clog2(NUM_PHASES) + 1;
    localparam int RUN_W = $clog2(PHASE_CYCLES + 1);
    localparam int RST_W = $clog2(RESET_CYCLES + 1);

    localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(NUM_PHASES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST   = RUN_W'(PHASE_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_LAST   = RST_W'(RESET_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-2:0] fail_code_q, fail_code_d;

    logic [RUN_W-1:0]  run_cnt;
    logic [RST_W-1:0]  rst_cnt;
    logic              in_run;
    logic              in_hold;
    logic              tohost_hit;
    logic              tohost_pass;
    logic              phase_rst;
    logic              hold_end;

    assign in_run  = (state_q == RUN);
    assign in_hold = (state_q == RST_HOLD);

    // Even values (including zero) written to tohost carry no verdict.
    assign tohost_hit  = mem_write && (mem_addr == TOHOST_ADDR)
                         && mem_wdata[0];
    assign tohost_pass = (mem_wdata == DATA_W'(TOHOST_PASS));

    assign phase_rst = in_run && (state_d == RST_HOLD);
    assign hold_end  = in_hold && (state_d == RUN);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        fail_code_d = fail_code_q;
        unique case (state_q)
            RST_HOLD: begin
                if (rst_cnt == RST_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tohost_hit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (tohost_pass) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d      = 1'b1;
                        fail_code_d = mem_wdata[DATA_W-1:1];
                    end
                end else if (run_cnt == RUN_LAST) begin
                    if (phase_q < LAST_PHASE) begin
                        phase_d = phase_q + PH_W'(1);
                        state_d = RST_HOLD;
                    end else begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RST_HOLD;
            end
        endcase
        cpu_rst_d = (state_d != RUN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RST_HOLD;
            cpu_rst_q   <= 1'b1;
            phase_q     <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_code_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_rst_q   <= cpu_rst_d;
            phase_q     <= phase_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            fail_code_q <= fail_code_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (1'b0),
        .inc_i (in_run),
        .q_o   (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (phase_rst),
        .inc_i (in_run && wb_valid),
        .q_o   (retire_cnt)
    );

    // Sized to reach PHASE_CYCLES, independent of CNT_W.
    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (phase_rst),
        .inc_i (in_run),
        .q_o   (run_cnt)
    );

    sat_counter #(.W(RST_W)) u_rst_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (hold_end),
        .inc_i (in_hold),
        .q_o   (rst_cnt)
    );

    assign cpu_rst   = cpu_rst_q;
    assign phase     = phase_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign fail_code = fail_code_q;

endmodule

// File: tb/tb_rv_test_sequencer.sv
// Bench for rv_test_sequencer: directed scenarios plus random stimulus
// checked every cycle against a phase/run-length model (CNT_W 32 and 4).
module tb_rv_test_sequencer;
    import rv_test_sequencer_pkg::*;

    localparam int NP   = 2;
    localparam int RC   = 2;
    localparam int PC   = 20;
    localparam logic [31:0] TH = 32'h0000_1000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        wb_valid = 1'b0;

    logic        cpu_rst_a, done_a, pass_a, fail_a, tmo_a;
    logic [1:0]  phase_a;
    logic [31:0] cyc_a, ret_a;
    logic [30:0] code_a;

    logic        cpu_rst_b, done_b, pass_b, fail_b, tmo_b;
    logic [1:0]  phase_b;
    logic [3:0]  cyc_b, ret_b;
    logic [30:0] code_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    rv_test_sequencer dut (
        .CLK(CLK), .RST(RST), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .wb_valid(wb_valid), .cpu_rst(cpu_rst_a),
        .phase(phase_a), .cycle_cnt(cyc_a), .retire_cnt(ret_a),
        .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(tmo_a),
        .fail_code(code_a)
    );

    rv_test_sequencer #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .wb_valid(wb_valid), .cpu_rst(cpu_rst_b),
        .phase(phase_b), .cycle_cnt(cyc_b), .retire_cnt(ret_b),
        .done(done_b), .pass(pass_b), .fail(fail_b), .timeout(tmo_b),
        .fail_code(code_b)
    );

    typedef struct {
        int     hold_left;
        int     run;
        int     phase;
        longint cyc;
        longint ret;
        bit     done;
        bit     pass;
        bit     fail;
        bit     tmo;
        longint code;
    } mdl_t;

    mdl_t m0, m4;
    bit   mvalid = 1'b0;

    function automatic mdl_t step(mdl_t m, bit rst, bit we,
                                  logic [31:0] a, logic [31:0] d,
                                  bit wb, longint mx);
        if (rst) begin
            m = '{default: 0};
            m.hold_left = RC;
            return m;
        end
        if (m.done) return m;
        if (m.hold_left > 0) begin
            m.hold_left--;
            return m;
        end
        m.cyc = (m.cyc < mx) ? m.cyc + 1 : mx;
        if (wb) m.ret = (m.ret < mx) ? m.ret + 1 : mx;
        m.run++;
        if (we && a == TH && d[0]) begin
            m.done = 1;
            if (d == 32'd1) m.pass = 1;
            else begin
                m.fail = 1;
                m.code = longint'(d >> 1);
            end
            return m;
        end
        if (m.run == PC) begin
            if (m.phase < NP - 1) begin
                m.phase++;
                m.ret = 0;
                m.run = 0;
                m.hold_left = RC;
            end else begin
                m.tmo = 1;
                m.done = 1;
            end
        end
        return m;
    endfunction

    always @(posedge CLK) begin
        m0 = step(m0, RST, mem_write, mem_addr, mem_wdata, wb_valid,
                  64'hFFFF_FFFF);
        m4 = step(m4, RST, mem_write, mem_addr, mem_wdata, wb_valid, 15);
        if (RST) mvalid = 1'b1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    always @(negedge CLK) begin
        if (mvalid) begin
            chk("cpu_rst",   cpu_rst_a, m0.done || m0.hold_left > 0);
            chk("phase",     phase_a, m0.phase);
            chk("cycle_cnt", cyc_a, m0.cyc);
            chk("retire",    ret_a, m0.ret);
            chk("done",      done_a, m0.done);
            chk("pass",      pass_a, m0.pass);
            chk("fail",      fail_a, m0.fail);
            chk("timeout",   tmo_a, m0.tmo);
            chk("fail_code", code_a, m0.code);
            chk("cpu_rst4",  cpu_rst_b, m4.done || m4.hold_left > 0);
            chk("phase4",    phase_b, m4.phase);
            chk("cycle4",    cyc_b, m4.cyc);
            chk("retire4",   ret_b, m4.ret);
            chk("done4",     done_b, m4.done);
            chk("pass4",     pass_b, m4.pass);
            chk("fail4",     fail_b, m4.fail);
            chk("timeout4",  tmo_b, m4.tmo);
            chk("code4",     code_b, m4.code);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic reset_seq();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        tick();
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    initial begin
        // Free-running two-phase timeout
        reset_seq();
        chk("t1 rst cpu_rst", cpu_rst_a, 1);
        chk("t1 rst cycle", cyc_a, 0);
        tick();
        chk("t1 hold1", cpu_rst_a, 1);
        tick();
        chk("t1 hold2", cpu_rst_a, 0);
        tick(PC);
        chk("t1 boundary cpu_rst", cpu_rst_a, 1);
        chk("t1 boundary phase", phase_a, 1);
        chk("t1 boundary cycle", cyc_a, 20);
        tick(1);
        chk("t1 rehold", cpu_rst_a, 1);
        tick(1 + PC);
        chk("t1 timeout", tmo_a, 1);
        chk("t1 done", done_a, 1);
        chk("t1 cycle", cyc_a, 40);
        chk("t1 cycle4 sat", cyc_b, 15);
        chk("t1 phase4", phase_b, 1);
        chk("t1 timeout4", tmo_b, 1);

        // Pass at run cycle 5
        reset_seq();
        tick(2 + 5);
        store(TH, 32'd1);
        chk("t2 pass", pass_a, 1);
        chk("t2 done", done_a, 1);
        chk("t2 cpu_rst", cpu_rst_a, 1);
        chk("t2 cycle", cyc_a, 6);
        tick(30);
        chk("t2 phase", phase_a, 0);
        chk("t2 pass hold", pass_a, 1);

        // Fail code
        reset_seq();
        tick(2 + 3);
        store(TH, 32'd7);
        chk("t3 fail", fail_a, 1);
        chk("t3 code", code_a, 3);
        chk("t3 pass", pass_a, 0);

        // Ignored stores, including one during cpu_rst
        reset_seq();
        store(TH, 32'd1);
        tick();
        store(TH + 32'd4, 32'd1);
        store(TH, 32'd0);
        store(TH, 32'd2);
        tick();
        chk("t4 done", done_a, 0);
        chk("t4 cycle", cyc_a, 4);

        // Tohost on the phase-end cycle
        reset_seq();
        tick(2 + PC - 1);
        store(TH, 32'd1);
        chk("t5 pass", pass_a, 1);
        chk("t5 phase", phase_a, 0);
        tick(3);
        chk("t5 no rerun", cyc_a, 20);

        // Retire count and clear at phase boundary
        reset_seq();
        tick(2);
        wb_valid = 1'b1;
        tick(7);
        wb_valid = 1'b0;
        tick();
        chk("t6 retire", ret_a, 7);
        tick(PC - 8);
        chk("t6 phase", phase_a, 1);
        chk("t6 retire clr", ret_a, 0);

        // Mid-run reset
        reset_seq();
        tick(2);
        wb_valid = 1'b1;
        tick(10);
        wb_valid = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t7 cycle", cyc_a, 0);
        chk("t7 retire", ret_a, 0);
        chk("t7 cpu_rst", cpu_rst_a, 1);
        tick(2);
        chk("t7 restart", cpu_rst_a, 0);
        chk("t7 phase", phase_a, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            int sel;
            RST       = ($urandom_range(0, 299) == 0) ||
                        (m0.done && $urandom_range(0, 7) == 0);
            wb_valid  = $urandom_range(0, 1) == 1;
            mem_write = $urandom_range(0, 39) == 0;
            mem_addr  = ($urandom_range(0, 3) == 0) ? TH + 32'd4 : TH;
            sel = $urandom_range(0, 5);
            case (sel)
                0: mem_wdata = 32'd0;
                1: mem_wdata = 32'd1;
                2: mem_wdata = 32'd2;
                3: mem_wdata = 32'd5;
                default: mem_wdata = $urandom;
            endcase
            tick();
        end
        RST = 1'b0;
        mem_write = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
